mem_access_unit: RTL and testbench

//  MEM-stage data-memory access unit. Sits between the EX/MEM register and the MEM/WB register.

---
 rtl/mem_access_unit.sv | 156 +++++++++++++++
 tb/tb_mem_access_unit.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// mem_access_unit
//   Data-memory access unit for the MEM stage. It turns a load or store into a
//   req/ack transaction on a variable-latency data memory. It stalls the
//   pipeline until the transaction finishes, returns zero-extended load data,
//   and flags misaligned, illegal (read+write) or timed-out accesses.
// Ports
//   clk, reset                   clock (rising edge); async active-low reset
//   MemRead_mem, MemWrite_mem    load / store in the MEM stage
//   size_mem                     0=byte 1=half 2=word 3=dword
//   alu_result_mem, wr_data_mem  effective address, low-aligned store data
//   dmem_req/we/addr/be/wdata    request to memory, held until dmem_ack
//   dmem_ack, dmem_rdata         one-cycle completion, read doubleword
//   dm_read_data_mem             load result to MEM/WB (holds between loads)
//   mem_stall                    freeze upstream pipeline registers
//   mem_err                      one-cycle error pulse in DONE
module mem_access_unit #(
  parameter int TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemRead_mem,
  input  logic        MemWrite_mem,
  input  logic [1:0]  size_mem,
  input  logic [63:0] alu_result_mem,
  input  logic [63:0] wr_data_mem,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [63:0] dmem_addr,
  output logic [7:0]  dmem_be,
  output logic [63:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [63:0] dmem_rdata,
  output logic [63:0] dm_read_data_mem,
  output logic        mem_stall,
  output logic        mem_err
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_t      state, state_nxt;
  logic [7:0]  wait_cnt;
  logic [1:0]  size_q;
  logic [2:0]  off_q;

  logic        op, legal, aligned;
  logic [2:0]  a;
  logic [7:0]  be_calc;
  logic [63:0] wdata_calc, rd_shift, rd_ext;

  assign op    = MemRead_mem | MemWrite_mem;
  assign a     = alu_result_mem[2:0];
  assign legal = aligned & ~(MemRead_mem & MemWrite_mem);

  always_comb begin
    aligned    = 1'b1;
    be_calc    = 8'hFF;
    wdata_calc = wr_data_mem;
    case (size_mem)
      2'd0: begin
        be_calc    = 8'h01 << a;
        wdata_calc = {8{wr_data_mem[7:0]}};
      end
      2'd1: begin
        aligned    = ~a[0];
        be_calc    = 8'h03 << a;
        wdata_calc = {4{wr_data_mem[15:0]}};
      end
      2'd2: begin
        aligned    = (a[1:0] == 2'b00);
        be_calc    = 8'h0F << a;
        wdata_calc = {2{wr_data_mem[31:0]}};
      end
      default: aligned = (a == 3'b000);
    endcase
  end

  // Load data uses the offset/size captured at issue, not the live inputs.
  assign rd_shift = dmem_rdata >> {off_q, 3'b000};
  always_comb begin
    rd_ext = rd_shift;
    case (size_q)
      2'd0:    rd_ext = {56'd0, rd_shift[7:0]};
      2'd1:    rd_ext = {48'd0, rd_shift[15:0]};
      2'd2:    rd_ext = {32'd0, rd_shift[31:0]};
      default: rd_ext = rd_shift;
    endcase
  end

  always_comb begin
    state_nxt = state;
    mem_stall = 1'b0;
    case (state)
      IDLE: begin
        mem_stall = op;
        if (op) state_nxt = legal ? BUSY : DONE;
      end
      BUSY: begin
        mem_stall = 1'b1;
        if (dmem_ack || wait_cnt == TO_LAST) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;  // ops seen here are the completed one
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state            <= IDLE;
      dmem_req         <= 1'b0;
      dmem_we          <= 1'b0;
      dmem_addr        <= '0;
      dmem_be          <= '0;
      dmem_wdata       <= '0;
      dm_read_data_mem <= '0;
      mem_err          <= 1'b0;
      wait_cnt         <= '0;
      size_q           <= '0;
      off_q            <= '0;
    end else begin
      state   <= state_nxt;
      mem_err <= 1'b0;  // pulse: only set on the edge into DONE
      case (state)
        IDLE: if (op) begin
          if (legal) begin
            dmem_req   <= 1'b1;
            dmem_we    <= MemWrite_mem;
            dmem_addr  <= {alu_result_mem[63:3], 3'b000};
            dmem_be    <= be_calc;
            dmem_wdata <= wdata_calc;
            size_q     <= size_mem;
            off_q      <= a;
            wait_cnt   <= '0;
          end else begin
            mem_err <= 1'b1;
          end
        end
        BUSY: begin
          if (dmem_ack) begin
            dmem_req <= 1'b0;
            if (!dmem_we) dm_read_data_mem <= rd_ext;
          end else if (wait_cnt == TO_LAST) begin
            dmem_req <= 1'b0;
            mem_err  <= 1'b1;
            if (!dmem_we) dm_read_data_mem <= '0;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;
  localparam int TIMEOUT = 15;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        MemRead_mem = 1'b0, MemWrite_mem = 1'b0;
  logic [1:0]  size_mem = '0;
  logic [63:0] alu_result_mem = '0, wr_data_mem = '0;
  logic        dmem_req, dmem_we;
  logic [63:0] dmem_addr, dmem_wdata, dm_read_data_mem;
  logic [7:0]  dmem_be;
  logic        dmem_ack;
  logic [63:0] dmem_rdata;
  logic        mem_stall, mem_err;

  logic        resp_ack = 1'b0, man_ack = 1'b0;
  logic [63:0] resp_rdata = '0, man_rdata = '0;
  assign dmem_ack   = resp_ack | man_ack;
  assign dmem_rdata = man_ack ? man_rdata : resp_rdata;

  mem_access_unit #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .MemRead_mem(MemRead_mem), .MemWrite_mem(MemWrite_mem),
    .size_mem(size_mem), .alu_result_mem(alu_result_mem), .wr_data_mem(wr_data_mem),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .dm_read_data_mem(dm_read_data_mem), .mem_stall(mem_stall), .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        req;
    logic        we;
    logic        err;
    logic [63:0] addr;
    logic [7:0]  be;
    logic [63:0] wdata;
    logic [63:0] dout;
    int          stall;
  } exp_t;

  exp_t sb[$];
  int errs = 0, checks = 0;
  int done_cnt = 0;
  logic [63:0] exp_last = '0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Memory model: acks after mem_waits request cycles; negative = never.
  int          mem_waits = 0;
  logic [63:0] mem_rdata = '0;
  int          wcnt = 0;
  always @(negedge clk) begin
    if (!reset) begin
      resp_ack = 1'b0; wcnt = 0;
    end else if (resp_ack) begin
      resp_ack = 1'b0; wcnt = 0;
    end else if (dmem_req && mem_waits >= 0) begin
      if (wcnt == mem_waits) begin
        resp_ack = 1'b1; resp_rdata = mem_rdata;
      end else wcnt++;
    end
  end

  // Monitor: counts stall cycles, captures the request, scores at DONE.
  int          stall_cnt = 0;
  logic        prev_stall = 1'b0, req_seen = 1'b0;
  logic        cap_we;
  logic [63:0] cap_addr, cap_wdata;
  logic [7:0]  cap_be;
  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      stall_cnt = 0; prev_stall = 1'b0; req_seen = 1'b0;
    end else begin
      if (mem_stall) stall_cnt++;
      if (dmem_req && !req_seen) begin
        req_seen = 1'b1; cap_we = dmem_we; cap_addr = dmem_addr;
        cap_be = dmem_be; cap_wdata = dmem_wdata;
      end else if (dmem_req) begin
        chk("req_hold_addr", dmem_addr, cap_addr);
        chk("req_hold_be", {56'd0, dmem_be}, {56'd0, cap_be});
      end
      if (prev_stall && !mem_stall) begin
        if (sb.size() == 0) chk("sb_nonempty", 64'd0, 64'd1);
        else begin
          e = sb.pop_front();
          chk("done_req_low", {63'd0, dmem_req}, 64'd0);
          chk("mem_err", {63'd0, mem_err}, {63'd0, e.err});
          chk("stall_cycles", 64'(stall_cnt), 64'(e.stall));
          chk("req_issued", {63'd0, req_seen}, {63'd0, e.req});
          chk("read_data", dm_read_data_mem, e.dout);
          if (e.req) begin
            chk("we", {63'd0, cap_we}, {63'd0, e.we});
            chk("addr", cap_addr, e.addr);
            chk("be", {56'd0, cap_be}, {56'd0, e.be});
            if (e.we) chk("wdata", cap_wdata, e.wdata);
          end
        end
        done_cnt++;
        stall_cnt = 0; req_seen = 1'b0;
      end else if (mem_err) begin
        chk("err_outside_done", {63'd0, mem_err}, 64'd0);
      end
      prev_stall = mem_stall;
    end
  end

  task automatic do_op(input logic rd, input logic wr, input logic [1:0] sz,
                       input logic [63:0] addr, input logic [63:0] d,
                       input int waits, input logic [63:0] rdata);
    exp_t e;
    int nb, a, start, guard;
    logic ok;
    nb = 1 << sz;
    a  = int'(addr[2:0]);
    ok = (a % nb == 0) && !(rd && wr);
    e.req = ok; e.we = wr; e.addr = {addr[63:3], 3'b000};
    e.be = '0; e.wdata = '0; e.dout = exp_last;
    for (int i = 0; i < 8; i++) begin
      if (i >= a && i < a + nb) e.be[i] = 1'b1;
      e.wdata[8*i +: 8] = d[8*(i % nb) +: 8];
    end
    if (!ok) begin
      e.err = 1'b1; e.stall = 1;
    end else if (waits < 0) begin
      e.err = 1'b1; e.stall = 1 + TIMEOUT;
      if (rd) e.dout = '0;
    end else begin
      e.err = 1'b0; e.stall = 2 + waits;
      if (rd) begin
        e.dout = '0;
        for (int i = 0; i < nb; i++) e.dout[8*i +: 8] = rdata[8*(a+i) +: 8];
      end
    end
    exp_last = e.dout;
    mem_waits = waits; mem_rdata = rdata;
    sb.push_back(e);
    MemRead_mem = rd; MemWrite_mem = wr; size_mem = sz;
    alu_result_mem = addr; wr_data_mem = d;
    start = done_cnt; guard = 0;
    while (done_cnt == start && guard < 200) begin
      @(negedge clk); #1; guard++;
    end
    if (done_cnt == start) begin
      chk("done_wait_expired", 64'd0, 64'd1);
      sb.delete();
    end
    @(posedge clk); #1;
    MemRead_mem = 1'b0; MemWrite_mem = 1'b0;
  endtask

  initial begin
    #2;
    chk("rst_req",   {63'd0, dmem_req}, 64'd0);
    chk("rst_we",    {63'd0, dmem_we}, 64'd0);
    chk("rst_addr",  dmem_addr, 64'd0);
    chk("rst_be",    {56'd0, dmem_be}, 64'd0);
    chk("rst_wdata", dmem_wdata, 64'd0);
    chk("rst_rdata", dm_read_data_mem, 64'd0);
    chk("rst_err",   {63'd0, mem_err}, 64'd0);
    chk("rst_stall", {63'd0, mem_stall}, 64'd0);
    @(posedge clk); #1; reset = 1'b1;
    @(posedge clk); #1;

    do_op(1, 0, 2'd3, 64'h40, 64'd0, 0, 64'h1122334455667788);    // LDUR dword
    do_op(1, 0, 2'd0, 64'h45, 64'd0, 0, 64'h1122334455667788);    // LDURB
    do_op(0, 1, 2'd1, 64'h12, 64'hBEEF, 3, 64'd0);                // STURH, 3 waits
    do_op(1, 0, 2'd2, 64'h42, 64'd0, 0, 64'd0);                   // misaligned word
    do_op(1, 0, 2'd2, 64'h44, 64'd0, 1, 64'hA1B2C3D4E5F60718);    // word, upper half
    do_op(1, 0, 2'd3, 64'h100, 64'd0, -1, 64'd0);                 // timeout
    do_op(0, 1, 2'd0, 64'h207, 64'h00000000000000A5, 0, 64'd0);   // STURB lane 7
    do_op(1, 1, 2'd3, 64'h300, 64'd0, 0, 64'd0);                  // read+write illegal
    do_op(0, 1, 2'd3, 64'h3F8, 64'h0123456789ABCDEF, 2, 64'd0);   // STUR dword
    do_op(1, 0, 2'd1, 64'h56, 64'd0, 0, 64'hFFEEDDCCBBAA9988);    // LDURH lane 6
    do_op(0, 1, 2'd2, 64'h61, 64'h12345678, 0, 64'd0);            // misaligned store

    // Reset in the 2nd BUSY cycle abandons the request.
    mem_waits = -1;
    MemRead_mem = 1'b1; size_mem = 2'd3; alu_result_mem = 64'h80;
    @(posedge clk); #1;
    chk("pre_rst_req", {63'd0, dmem_req}, 64'd1);
    @(posedge clk); #2;
    reset = 1'b0; MemRead_mem = 1'b0;
    #1;
    chk("rst_mid_req",   {63'd0, dmem_req}, 64'd0);
    chk("rst_mid_stall", {63'd0, mem_stall}, 64'd0);
    chk("rst_mid_rdata", dm_read_data_mem, 64'd0);
    @(negedge clk);
    @(posedge clk); #1;
    reset = 1'b1;
    man_rdata = 64'hDEADBEEFCAFEF00D; man_ack = 1'b1;
    @(posedge clk); #1;
    man_ack = 1'b0;
    chk("late_ack_req",   {63'd0, dmem_req}, 64'd0);
    chk("late_ack_stall", {63'd0, mem_stall}, 64'd0);
    chk("late_ack_rdata", dm_read_data_mem, 64'd0);
    chk("late_ack_err",   {63'd0, mem_err}, 64'd0);
    exp_last = '0;
    do_op(1, 0, 2'd3, 64'h88, 64'd0, 0, 64'h0F0E0D0C0B0A0908);
    do_op(1, 0, 2'd0, 64'h91, 64'd0, 0, 64'h0F0E0D0C0B0A0908);
    repeat (3) @(posedge clk);
    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errs);
    $fatal(1);
  end

endmodule
